shift_counter_param: RTL and testbench

- Parametrised ring/Johnson shift counter, the next generation of the team's fixed 4-bit ring/Johnson counter.
- Configurable width; run-time mode (ring or Johnson) and direction select; count enable; parallel load.
- Registered terminal-count pulse and a combinational illegal-state flag.
- Used as a sequence/phase generator and divide-by-N (ring) or divide-by-2N (Johnson) source in lab datapaths.

---
 rtl/shift_counter_param.sv | 51 +++++
 tb/tb_shift_counter_param.sv | 105 ++++++++++
 2 files changed

// File: rtl/shift_counter_param.sv
// shift_counter_param: WIDTH-bit ring/Johnson shift counter with terminal-count pulse and illegal-state flag; SHIFT_COUNTER_SELF_CORRECT_EN enables one-step recovery from illegal states
module shift_counter_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             err
);
  localparam logic [WIDTH-1:0] seed = WIDTH'(1);
  logic [WIDTH-1:0] home, shift, step;
  logic [WIDTH-2:0] edges;
  logic fix;
  always_comb begin
    home = mode ? '0 : seed;
    edges = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    err = mode ? |(edges & (edges - (WIDTH-1)'(1))) : (q == '0) || |(q & (q - seed));
    shift = mode ? (dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]})
                 : (dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]});
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    fix = err;
`else
    fix = 1'b0;
`endif
    step = fix ? home : shift;
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q <= d;
      tc <= 1'b0;
    end else if (preset) begin
      q <= seed;
      tc <= 1'b0;
    end else if (en) begin
      q <= step;
      tc <= !fix && step == home;
    end else begin
      tc <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_counter_param.sv
// tb_shift_counter_param: directed-vector self-checking bench for shift_counter_param at WIDTH=4
module tb_shift_counter_param;
  logic clk = 1'b0;
  logic clr, preset, load, en, mode, dir;
  logic [3:0] d, q;
  logic tc, err;
  int vectors = 0;
  int miscompares = 0;
  shift_counter_param #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .preset(preset), .load(load), .d(d),
    .en(en), .mode(mode), .dir(dir), .q(q), .tc(tc), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic state(input string tag, input logic [3:0] eq, input logic etc, input logic eerr);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".tc"}, 32'(tc), 32'(etc));
    chk({tag, ".err"}, 32'(err), 32'(eerr));
  endtask
  logic [3:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] john_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] ring_r [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
  logic [3:0] lock [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic lock_err = 1'b0;
`else
  logic [3:0] lock [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic lock_err = 1'b1;
`endif
  initial begin
    clr = 1'b0; preset = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; d = '0;
    tick;
    state("reset", 4'b0000, 1'b0, 1'b1);
    clr = 1'b1; preset = 1'b1;
    tick;
    state("preset", 4'b0001, 1'b0, 1'b0);
    preset = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      state($sformatf("ring_l%0d", i), ring_l[i], i == 3, 1'b0);
    end
    clr = 1'b0;
    tick;
    clr = 1'b1; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      state($sformatf("john_l%0d", i), john_l[i], i == 7, 1'b0);
    end
    mode = 1'b0; dir = 1'b1; preset = 1'b1; en = 1'b0;
    tick;
    state("preset2", 4'b0001, 1'b0, 1'b0);
    preset = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      state($sformatf("ring_r%0d", i), ring_r[i], i == 3, 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      state($sformatf("hold%0d", i), 4'b0100, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick;
    state("resume", 4'b0010, 1'b0, 1'b0);
    clr = 1'b0; preset = 1'b1;
    tick;
    state("clr_wins", 4'b0000, 1'b0, 1'b1);
    clr = 1'b1;
    tick;
    state("preset3", 4'b0001, 1'b0, 1'b0);
    preset = 1'b0; load = 1'b1; d = 4'b0101; mode = 1'b1; dir = 1'b0; en = 1'b0;
    tick;
    state("load", 4'b0101, 1'b0, 1'b1);
    load = 1'b0; en = 1'b1;
    tick;
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    state("john_fix", 4'b0000, 1'b0, 1'b0);
`else
    state("john_bad", 4'b1011, 1'b0, 1'b1);
`endif
    clr = 1'b0;
    tick;
    clr = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      state($sformatf("ring0_%0d", i), lock[i], 1'b0, i == 0 ? lock_err : 1'b0 | lock_err);
    end
    en = 1'b0; mode = 1'b1;
    #1;
    chk("mode_q", 32'(q), 32'(lock[3]));
    chk("mode_err", 32'(err), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
